// File: rtl/mbt_fb_reader_if.sv
// Bundle between mbt_fb_reader and its surroundings: pixel tick, frame-ready flag,
// BRAM read port B and the VGA pin group.
interface mbt_fb_reader_if;
  logic        pix_ce;
  logic        fb_valid;
  logic        bram_en;
  logic [16:0] bram_addr;
  logic [31:0] bram_dout;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        frame_start;
  logic [9:0]  px_x;
  logic [9:0]  px_y;

  modport master (
    input  pix_ce, fb_valid, bram_dout,
    output bram_en, bram_addr, vga_r, vga_g, vga_b,
           hsync, vsync, active, frame_start, px_x, px_y
  );

  modport slave (
    output pix_ce, fb_valid, bram_dout,
    input  bram_en, bram_addr, vga_r, vga_g, vga_b,
           hsync, vsync, active, frame_start, px_x, px_y
  );
endinterface

// File: rtl/mbt_fb_reader.sv
// Frame-buffer read side: VGA timing, one BRAM word fetch per 4 pixels, byte-lane
// unpacking and iteration-count to RGB444 mapping, all delayed 2 pixel ticks.
module mbt_fb_reader #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter int WORDS_PER_LINE = 160,
  parameter int RD_LAT         = 1
) (
  input  logic            clk,
  input  logic            rst,
  mbt_fb_reader_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEG    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [16:0] LAST_WORD = 17'(V_ACTIVE * WORDS_PER_LINE - 1);
  localparam logic [6:0]  N_IN_SET  = 7'h7F;

  // Per-pixel sideband travelling alongside the fetched data.
  typedef struct packed {
    logic [1:0] lane;
    logic       act;
    logic       fv;
    logic       hs_n;
    logic       vs_n;
  } side_t;

  localparam side_t SIDE_RST = '{lane: 2'd0, act: 1'b0, fv: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  logic [9:0]        r_h;
  logic [9:0]        r_v;
  logic [16:0]       r_word_cnt;
  logic              r_frame_valid;
  logic              r_bram_en;
  logic [16:0]       r_bram_addr;
  logic [RD_LAT-1:0] r_en_d;
  logic [27:0]       r_rd_hold;
  logic [27:0]       r_word;
  side_t             r_s1;
  side_t             r_s2;
  logic [3:0]        r_r;
  logic [3:0]        r_g;
  logic [3:0]        r_b;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_active;

  logic              w_origin;
  logic              w_h_wrap;
  logic              w_v_wrap;
  logic              w_vis;
  logic              w_fv;
  logic              w_fetch;
  logic              w_group_start;
  logic              w_dvalid;
  logic [16:0]       w_word_base;
  logic [27:0]       w_dout_n;
  logic [27:0]       w_word_in;
  side_t             w_side;
  logic [6:0]        w_n;
  logic [11:0]       w_rgb;

  assign w_origin = (r_h == 10'd0) && (r_v == 10'd0);
  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);
  assign w_vis    = (r_h < H_VIS) && (r_v < V_VIS);

  // The frame flag is latched at (0,0) but must already govern that first tick.
  assign w_fv        = w_origin ? bus.fb_valid : r_frame_valid;
  assign w_fetch     = bus.pix_ce && w_vis && w_fv && (r_h[1:0] == 2'b00);
  assign w_word_base = w_origin ? 17'd0 : r_word_cnt;

  assign w_side.lane = r_h[1:0];
  assign w_side.act  = w_vis;
  assign w_side.fv   = w_fv;
  assign w_side.hs_n = !((r_h >= HS_BEG) && (r_h < HS_END));
  assign w_side.vs_n = !((r_v >= VS_BEG) && (r_v < VS_END));

  // Byte bit 7 never reaches the colour map, so only 7 bits per lane are kept.
  assign w_dout_n      = {bus.bram_dout[30:24], bus.bram_dout[22:16],
                          bus.bram_dout[14:8],  bus.bram_dout[6:0]};
  assign w_dvalid      = r_en_d[RD_LAT-1];
  assign w_word_in     = w_dvalid ? w_dout_n : r_rd_hold;
  assign w_group_start = r_s1.act && r_s1.fv && (r_s1.lane == 2'b00);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    w_n   = r_word[6:0];
    w_rgb = 12'h000;
    case (r_s2.lane)
      2'd1:    w_n = r_word[13:7];
      2'd2:    w_n = r_word[20:14];
      2'd3:    w_n = r_word[27:21];
      default: w_n = r_word[6:0];
    endcase
    if (r_s2.act && r_s2.fv && (w_n != N_IN_SET)) begin
      w_rgb = {w_n[3:0], w_n[5:2], w_n[6:3]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h           <= 10'd0;
      r_v           <= 10'd0;
      r_word_cnt    <= 17'd0;
      r_frame_valid <= 1'b0;
      r_bram_en     <= 1'b0;
      r_bram_addr   <= 17'd0;
      r_en_d        <= '0;
      r_rd_hold     <= 28'd0;
      r_word        <= 28'd0;
      r_s1          <= SIDE_RST;
      r_s2          <= SIDE_RST;
      r_r           <= 4'd0;
      r_g           <= 4'd0;
      r_b           <= 4'd0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_active      <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register samples
      // the pre-edge values of its neighbours, which is what makes the pipeline shift.
      r_bram_en <= 1'b0;
      r_en_d[0] <= r_bram_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_en_d[i] <= r_en_d[i-1];
      end
      if (w_dvalid) begin
        r_rd_hold <= w_dout_n;
      end

      if (bus.pix_ce) begin
        r_h <= w_h_wrap ? 10'd0 : r_h + 10'd1;
        if (w_h_wrap) begin
          r_v <= w_v_wrap ? 10'd0 : r_v + 10'd1;
        end
        if (w_origin) begin
          r_frame_valid <= bus.fb_valid;
        end

        if (w_fetch) begin
          r_bram_en   <= 1'b1;
          r_bram_addr <= w_word_base;
          r_word_cnt  <= (w_word_base == LAST_WORD) ? 17'd0 : w_word_base + 17'd1;
        end else if (w_origin) begin
          r_word_cnt  <= 17'd0;
        end

        r_s1 <= w_side;
        r_s2 <= r_s1;
        if (w_group_start) begin
          r_word <= w_word_in;
        end

        {r_r, r_g, r_b} <= w_rgb;
        r_hsync         <= r_s2.hs_n;
        r_vsync         <= r_s2.vs_n;
        r_active        <= r_s2.act;
      end
    end
  end

  assign bus.bram_en     = r_bram_en;
  assign bus.bram_addr   = r_bram_addr;
  assign bus.vga_r       = r_r;
  assign bus.vga_g       = r_g;
  assign bus.vga_b       = r_b;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.active      = r_active;
  assign bus.frame_start = bus.pix_ce && w_origin && !rst;
  assign bus.px_x        = r_h;
  assign bus.px_y        = r_v;

endmodule

// File: tb/tb_mbt_fb_reader.sv
// Bench for mbt_fb_reader: a full-size instance for reset, line fetch and sync
// timing, and a shrunken-geometry instance for frame wrap, fb_valid and palette.
module tb_mbt_fb_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b;
  logic rst_s;

  mbt_fb_reader_if ifb ();
  mbt_fb_reader_if ifs ();

  mbt_fb_reader u_dut_vga (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  mbt_fb_reader #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .WORDS_PER_LINE(4), .RD_LAT(1)
  ) u_dut_small (
    .clk (clk),
    .rst (rst_s),
    .bus (ifs)
  );

  logic [31:0] mem [0:76799];

  always @(posedge clk) begin
    if (ifb.bram_en) ifb.bram_dout <= mem[int'(ifb.bram_addr)];
    if (ifs.bram_en) ifs.bram_dout <= mem[int'(ifs.bram_addr)];
  end

  logic        sel;
  logic        o_en, o_hs, o_vs, o_act, o_fs;
  logic [16:0] o_addr;
  logic [11:0] o_rgb;
  logic [9:0]  o_x, o_y;

  always_comb begin
    o_en = ifb.bram_en; o_addr = ifb.bram_addr; o_rgb = {ifb.vga_r, ifb.vga_g, ifb.vga_b};
    o_hs = ifb.hsync;   o_vs = ifb.vsync;       o_act = ifb.active; o_fs = ifb.frame_start;
    o_x  = ifb.px_x;    o_y  = ifb.px_y;
    if (sel) begin
      o_en = ifs.bram_en; o_addr = ifs.bram_addr; o_rgb = {ifs.vga_r, ifs.vga_g, ifs.vga_b};
      o_hs = ifs.hsync;   o_vs = ifs.vsync;       o_act = ifs.active; o_fs = ifs.frame_start;
      o_x  = ifs.px_x;    o_y  = ifs.px_y;
    end
  end

  typedef struct {
    int          t;
    logic        act;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pix_t;

  pix_t exp_q [$];

  int   total = 0;
  int   bad   = 0;
  int   t, line_cnt, frame_cnt, last_addr;
  logic fv_cur, fb_drive;
  int   g_htot, g_vtot, g_hact, g_vact, g_hs0, g_hs1, g_vs0, g_vs1, g_wpl;
  logic [11:0] lit_b [4];
  logic [11:0] lit_s [4];
  logic        fv_start [8];
  int          tog_v [8];
  int          v_now;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, exp, t);
    end
  endtask

  // Iteration count n lives in the low 7 bits; 127 means inside the set.
  function automatic logic [11:0] colour(input int b);
    int n;
    n = b % 128;
    if (n == 127) return 12'h000;
    return 12'((n % 16) * 256 + ((n / 4) % 16) * 16 + (n / 8));
  endfunction

  task automatic drive_pce(input logic val);
    if (sel) ifs.pix_ce = val; else ifb.pix_ce = val;
  endtask

  task automatic drive_rst(input logic val);
    if (sel) rst_s = val; else rst_b = val;
  endtask

  task automatic model_reset();
    pix_t r;
    r.t = -1; r.act = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.rgb = 12'h000;
    t = 0; line_cnt = 0; frame_cnt = 0; last_addr = -1; fv_cur = 1'b0;
    exp_q.delete();
    exp_q.push_back(r);
    exp_q.push_back(r);
  endtask

  task automatic reset_seq(input int cycles);
    drive_rst(1'b1);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      drive_pce(c % 4 == 0);
      #1;
      check("rst_hsync", 32'(o_hs), 32'd1);
      check("rst_vsync", 32'(o_vs), 32'd1);
      check("rst_rgb", 32'(o_rgb), 32'd0);
      check("rst_bram_en", 32'(o_en), 32'd0);
      check("rst_active", 32'(o_act), 32'd0);
      check("rst_frame_start", 32'(o_fs), 32'd0);
      check("rst_px_x", 32'(o_x), 32'd0);
    end
    @(negedge clk);
    drive_pce(1'b0);
    drive_rst(1'b0);
    model_reset();
  endtask

  task automatic do_tick(input int gap);
    int   h, v, addr, lane;
    logic vis, fetch;
    pix_t p, q;
    h = t % g_htot;
    v = (t / g_htot) % g_vtot;
    if (h == 0 && v == 0) fv_cur = fb_drive;
    vis   = (h < g_hact) && (v < g_vact);
    fetch = vis && fv_cur && (h % 4 == 0);
    addr  = v * g_wpl + h / 4;
    lane  = h % 4;
    p.t   = t;
    p.act = vis;
    p.hs  = !(h >= g_hs0 && h < g_hs1);
    p.vs  = !(v >= g_vs0 && v < g_vs1);
    p.rgb = 12'h000;
    if (vis && fv_cur) p.rgb = colour(int'((mem[addr] >> (8 * lane)) & 32'hFF));
    exp_q.push_back(p);

    @(negedge clk);
    drive_pce(1'b1);
    #1;
    check("px_x", 32'(o_x), 32'(h));
    check("px_y", 32'(o_y), 32'(v));
    check("frame_start", 32'(o_fs), 32'(h == 0 && v == 0));
    check("bram_en_idle", 32'(o_en), 32'd0);

    @(negedge clk);
    drive_pce(1'b0);
    #1;
    check("bram_en", 32'(o_en), 32'(fetch));
    if (fetch) check("bram_addr", 32'(o_addr), 32'(addr));
    if (o_en) begin
      line_cnt++;
      frame_cnt++;
      last_addr = int'(o_addr);
    end
    q = exp_q.pop_front();
    check("active", 32'(o_act), 32'(q.act));
    check("hsync", 32'(o_hs), 32'(q.hs));
    check("vsync", 32'(o_vs), 32'(q.vs));
    check("rgb", 32'(o_rgb), 32'(q.rgb));
    if (q.t >= 0 && q.t < 4) check("first_pixels", 32'(o_rgb), 32'(sel ? lit_s[q.t] : lit_b[q.t]));

    for (int i = 2; i < gap; i++) begin
      @(negedge clk);
      #1;
      check("bram_en_gap", 32'(o_en), 32'd0);
    end

    if (h == g_htot - 1) begin
      check("line_fetches", 32'(line_cnt), 32'((v < g_vact && fv_cur) ? g_wpl : 0));
      line_cnt = 0;
      if (v == g_vtot - 1) begin
        check("frame_fetches", 32'(frame_cnt), 32'(fv_cur ? g_vact * g_wpl : 0));
        if (fv_cur) check("last_addr", 32'(last_addr), 32'(g_vact * g_wpl - 1));
        frame_cnt = 0;
      end
    end
    t++;
  endtask

  initial begin
    rst_b = 1'b1; rst_s = 1'b1; sel = 1'b0;
    ifb.pix_ce = 1'b0; ifb.fb_valid = 1'b1;
    ifs.pix_ce = 1'b0; ifs.fb_valid = 1'b0;
    fb_drive = 1'b1;
    lit_b[0] = 12'h100; lit_b[1] = 12'h200; lit_b[2] = 12'h300; lit_b[3] = 12'h410;
    lit_s[0] = 12'h000; lit_s[1] = 12'h000; lit_s[2] = 12'h552; lit_s[3] = 12'h000;
    for (int k = 0; k < 76800; k++) mem[k] = {8'(k + 4), 8'(k + 3), 8'(k + 2), 8'(k + 1)};

    // Full 640x480 timing: reset, three whole lines, then a mid-line reset.
    g_htot = 800; g_vtot = 525; g_hact = 640; g_vact = 480;
    g_hs0 = 656; g_hs1 = 752; g_vs0 = 490; g_vs1 = 492; g_wpl = 160;
    reset_seq(12);
    for (int s = 0; s < 3 * 800 + 37; s++) do_tick($urandom_range(4, 2));

    @(negedge clk);
    drive_pce(1'b1);
    drive_rst(1'b1);
    @(negedge clk);
    drive_pce(1'b0);
    #1;
    check("midline_rst_px_x", 32'(o_x), 32'd0);
    check("midline_rst_px_y", 32'(o_y), 32'd0);
    check("midline_rst_en", 32'(o_en), 32'd0);
    check("midline_rst_hsync", 32'(o_hs), 32'd1);
    check("midline_rst_rgb", 32'(o_rgb), 32'd0);
    drive_rst(1'b0);
    model_reset();
    for (int s = 0; s < 40; s++) do_tick($urandom_range(4, 2));

    // Shrunken geometry: whole frames with fb_valid dropped and raised mid-frame.
    sel = 1'b1;
    g_htot = 24; g_vtot = 10; g_hact = 16; g_vact = 6;
    g_hs0 = 18; g_hs1 = 21; g_vs0 = 7; g_vs1 = 9; g_wpl = 4;
    fv_start[0] = 1'b1; tog_v[0] = g_vtot;
    fv_start[1] = 1'b1; tog_v[1] = 3;
    fv_start[2] = 1'b0; tog_v[2] = 3;
    fv_start[3] = 1'b1; tog_v[3] = g_vtot;
    for (int f = 4; f < 8; f++) begin
      fv_start[f] = 1'($urandom_range(1, 0));
      tog_v[f]    = $urandom_range(g_vtot, 1);
    end
    mem[0] = 32'h0015FF7F;
    reset_seq(6);
    for (int f = 0; f < 8; f++) begin
      for (int k = 1; k < g_vact * g_wpl; k++) mem[k] = $urandom;
      for (int s = 0; s < g_htot * g_vtot; s++) begin
        v_now    = s / g_htot;
        fb_drive = (v_now < tog_v[f]) ? fv_start[f] : !fv_start[f];
        ifs.fb_valid = fb_drive;
        do_tick($urandom_range(4, 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mbt_fb_reader.md
Name: mbt_fb_reader

Overview:
Read side of the Mandelbrot frame buffer. The engine writes BRAM port A as 32-bit words, each holding 4 pixels, one byte lane per pixel, with an iteration count in bits [6:0]. This block generates 640x480 VGA timing and fetches words from BRAM port B. It unpacks the byte lanes into a per-pixel stream and maps each iteration count to 12-bit RGB. It sits between the frame-buffer BRAM and the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixel ticks)
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
WORDS_PER_LINE, 160, 32-bit words per visible line (H_ACTIVE/4)
RD_LAT, 1, BRAM port-B read latency in clk cycles

Ports:
clk  in  1  system clock (same clock as the engine)
rst  in  1  synchronous, active-high reset
pix_ce  in  1  pixel-tick enable, one clk wide; spacing between ticks >= RD_LAT+1 clks
fb_valid  in  1  engine frame complete (engine ready); sampled once per frame
bram_en  out  1  port-B read enable, one-clk pulse per fetch
bram_addr  out  17  port-B word address
bram_dout  in  32  port-B read data; pixel x%4 = k in bits [8k+7:8k]
vga_r, vga_g, vga_b  out  4 each  pixel colour
hsync, vsync  out  1 each  active-low syncs
active  out  1  high while the displayed pixel is visible
frame_start  out  1  one-clk pulse on the pix_ce tick where counters are (0,0)
px_x, px_y  out  10 each  debug: current counter position (not pipeline-delayed)

Behaviour:
- Reset values: h=v=0, word counter=0, bram_en=0, bram_addr=0, rgb=0, hsync=vsync=1, active=0, frame_start=0, fb_valid latch=0, all pipeline stages cleared.
- Reset while rst=1 overrides pix_ce. A mid-line reset returns the counters to (0,0) on the next clk.
- Counters advance only on pix_ce. H_TOTAL=800, V_TOTAL=525. h wraps 799->0 and increments v. v wraps 524->0.
- Sync windows:
  - hsync=0 for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
  - vsync=0 for v in [490, 492).
- Frame latch: on the pix_ce tick at (0,0), frame_valid <= fb_valid. It is held for the whole frame, so a mid-frame fb_valid change has no effect until the next frame.
- Fetch: on a pix_ce tick with h<640, v<480, h[1:0]=0 and frame_valid=1:
  - register bram_en=1 and bram_addr=word counter;
  - increment the word counter.
  - Otherwise bram_en=0. bram_en is one clk wide.
  - No fetches occur during blanking or when frame_valid=0.
- Address generation: incremental, no multiplier. The word counter resets to 0 at frame start. Address = v*160 + h/4, so the last address is 76799.
- Pipeline, measured in pix_ce ticks, with counters at (h,v) on tick n:
  - tick n: fetch issued; sideband {h[1:0], active, hs, vs} captured into stage 1.
  - tick n+1: bram_dout captured into the word register if stage 1 is a group start; sideband moves to stage 2.
  - tick n+2: output registers load the byte lane selected by stage-2 h[1:0], plus the syncs and active.
  - Outputs for (h,v) are therefore driven from tick n+2 to tick n+3. Syncs are delayed by the same 2 ticks, so pixel-to-sync alignment is exact.
  - The word register holds between group starts.
- Colour map: n = byte[6:0]; byte bit 7 is ignored.
  - n = 7'h7F (inside the set): rgb = 0.
  - Otherwise r=n[3:0], g=n[5:2], b=n[6:3].
  - rgb = 0 whenever active=0 or frame_valid=0.
- frame_start is a one-clk pulse, asserted for the clk of the pix_ce tick at (0,0). It is not delayed.

Test Plan:
1. Reset: rst=1 for 3 clks, pix_ce every 4 clks, fb_valid=1 -> hsync=vsync=1, rgb=0, bram_en=0 throughout. The first pix_ce after release gives bram_en=1 with addr 0 one clk later.
2. Line fetch: word k = {k+4,k+3,k+2,k+1} bytes, so word 0 = 32'h04030201 -> pixels 0..3 output n=1..4, with the first pixel appearing 2 ticks after (0,0). Exactly 160 bram_en pulses per visible line; line 0 addresses 0..159, line 1 addresses 160..319.
3. Timing: hsync low for ticks 656..751 (96 ticks); vsync low on lines 490-491; frame_start exactly once per 420000 pix_ce ticks; no bram_en on lines 480..524.
4. Wrap: the last fetch is addr 76799 at v=479, h=636. The first fetch of the next frame is addr 0.
5. Palette: byte 0x7F -> rgb 000; byte 0xFF -> rgb 000; byte 0x15 -> r=5, g=5, b=2; byte 0x00 -> rgb 000.
6. fb_valid: drop to 0 at v=100 -> the current frame is unchanged. The next frame has no bram_en and rgb=0 while syncs continue. Raise it again -> fetches resume from addr 0 at the following frame.
